// File: rtl/spmm_pe_scheduler_if.sv
`default_nettype none
// spmm_pe_scheduler_if: row stream, PE broadcast/collect bus and result stream of the SPMM PE scheduler.
// slave = scheduler side, master = surrounding fetch logic / PE pool / consumer.
interface spmm_pe_scheduler_if #(
   parameter int DATA_WIDTH       = 8,
   parameter int DOT_PRODUCT_SIZE = 5,
   parameter int NUM_PE           = 4,
   parameter int ROW_IDX_WIDTH    = 8
);
   localparam int COL_IDX_WIDTH   = $clog2(DOT_PRODUCT_SIZE);
   localparam int NODE_INFO_WIDTH = COL_IDX_WIDTH + 1;

   logic                                  row_valid_i;
   logic                                  row_ready_o;
   logic [ROW_IDX_WIDTH-1:0]              row_idx_i;
   logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] col_idx_i;
   logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    value_i;
   logic [NODE_INFO_WIDTH-1:0]            node_info_i;
   logic [NUM_PE-1:0]                     pe_valid_o;
   logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] pe_col_idx_o;
   logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    pe_value_o;
   logic [NODE_INFO_WIDTH-1:0]            pe_node_info_o;
   logic [NUM_PE-1:0]                     pe_ready_i;
   logic [NUM_PE*DATA_WIDTH-1:0]          pe_result_i;
   logic                                  res_valid_o;
   logic                                  res_ready_i;
   logic [ROW_IDX_WIDTH-1:0]              res_row_idx_o;
   logic [DATA_WIDTH-1:0]                 res_data_o;
   logic                                  err_o;
   logic [31:0]                           perf_rows_o;
   logic [31:0]                           perf_stall_o;

   modport slave (
      input  row_valid_i, row_idx_i, col_idx_i, value_i, node_info_i,
      input  pe_ready_i, pe_result_i, res_ready_i,
      output row_ready_o, pe_valid_o, pe_col_idx_o, pe_value_o, pe_node_info_o,
      output res_valid_o, res_row_idx_o, res_data_o, err_o, perf_rows_o, perf_stall_o
   );

   modport master (
      output row_valid_i, row_idx_i, col_idx_i, value_i, node_info_i,
      output pe_ready_i, pe_result_i, res_ready_i,
      input  row_ready_o, pe_valid_o, pe_col_idx_o, pe_value_o, pe_node_info_o,
      input  res_valid_o, res_row_idx_o, res_data_o, err_o, perf_rows_o, perf_stall_o
   );
endinterface
`default_nettype wire

// File: rtl/spmm_pe_scheduler.sv
`default_nettype none
// spmm_pe_scheduler: issues CSR rows to the lowest idle PE and returns results in arrival order.
// Optional performance counters are built when SPMM_SCHED_PERF_EN is defined.
module spmm_pe_scheduler #(
   parameter int DATA_WIDTH       = 8,
   parameter int DOT_PRODUCT_SIZE = 5,
   parameter int NUM_PE           = 4,
   parameter int ROW_IDX_WIDTH    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   spmm_pe_scheduler_if.slave  bus
);
   localparam int COL_IDX_WIDTH   = $clog2(DOT_PRODUCT_SIZE);
   localparam int NODE_INFO_WIDTH = COL_IDX_WIDTH + 1;
   localparam int PW              = $clog2(NUM_PE);
   localparam int CW              = $clog2(NUM_PE + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} slot_e;

   slot_e                                   r_st    [NUM_PE];
   slot_e                                   w_st_nx [NUM_PE];
   logic [ROW_IDX_WIDTH-1:0]                r_tag   [NUM_PE];
   logic [DATA_WIDTH-1:0]                   r_res   [NUM_PE];
   logic [PW-1:0]                           r_fifo  [NUM_PE];
   logic [PW-1:0]                           r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]                           r_cnt;
   logic                                    r_rdy_en;
   logic                                    r_err;
   logic [NUM_PE-1:0]                       r_pe_valid;
   logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] r_pe_col;
   logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    r_pe_val;
   logic [NODE_INFO_WIDTH-1:0]              r_pe_ni;

   logic                                    w_any_idle, w_acc, w_pop, w_head_done;
   logic [PW-1:0]                           w_tgt, w_head;
   logic [NUM_PE-1:0]                       w_spur;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(NUM_PE - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      w_any_idle = 1'b0;
      w_tgt      = '0;
      for (int k = NUM_PE - 1; k >= 0; k--) begin
         if (r_st[k] == S_IDLE) begin
            w_any_idle = 1'b1;
            w_tgt      = PW'(k);
         end
      end
   end

   assign w_head      = r_fifo[r_rd_ptr];
   assign w_head_done = (r_cnt != '0) && (r_st[w_head] == S_DONE);
   assign w_acc       = bus.row_valid_i && bus.row_ready_o;
   assign w_pop       = w_head_done && bus.res_ready_i;

   // An accept only hits an IDLE slot and a pop only a DONE one, so the branches never collide.
   always_comb begin
      for (int k = 0; k < NUM_PE; k++) begin
         w_st_nx[k] = r_st[k];
         w_spur[k]  = bus.pe_ready_i[k] && (r_st[k] != S_BUSY);
         if (w_acc && (w_tgt == PW'(k)))
            w_st_nx[k] = S_BUSY;
         else if (bus.pe_ready_i[k] && (r_st[k] == S_BUSY))
            w_st_nx[k] = S_DONE;
         else if (w_pop && (w_head == PW'(k)))
            w_st_nx[k] = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_PE; k++) r_st[k] <= S_IDLE;
      end else begin
         for (int k = 0; k < NUM_PE; k++) r_st[k] <= w_st_nx[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_PE; k++) begin
            r_tag[k] <= '0;
            r_res[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_PE; k++) begin
            if (w_acc && (w_tgt == PW'(k)))
               r_tag[k] <= bus.row_idx_i;
            if (bus.pe_ready_i[k] && (r_st[k] == S_BUSY))
               r_res[k] <= bus.pe_result_i[DATA_WIDTH*k +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_PE; k++) r_fifo[k] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_rdy_en   <= 1'b0;
         r_err      <= 1'b0;
         r_pe_valid <= '0;
         r_pe_col   <= '0;
         r_pe_val   <= '0;
         r_pe_ni    <= '0;
      end else begin
         r_rdy_en   <= 1'b1;
         r_err      <= r_err | (|w_spur);
         r_pe_valid <= '0;
         if (w_acc) begin
            r_fifo[r_wr_ptr]  <= w_tgt;
            r_wr_ptr          <= f_inc(r_wr_ptr);
            r_pe_valid[w_tgt] <= 1'b1;
            r_pe_col          <= bus.col_idx_i;
            r_pe_val          <= bus.value_i;
            r_pe_ni           <= bus.node_info_i;
         end
         if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
         if (w_acc && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (!w_acc && w_pop) r_cnt <= r_cnt - CW'(1);
      end
   end

   // r_rdy_en keeps the input stalled until the first edge after reset release.
   assign bus.row_ready_o    = r_rdy_en && w_any_idle;
   assign bus.pe_valid_o     = r_pe_valid;
   assign bus.pe_col_idx_o   = r_pe_col;
   assign bus.pe_value_o     = r_pe_val;
   assign bus.pe_node_info_o = r_pe_ni;
   assign bus.res_valid_o    = w_head_done;
   assign bus.res_row_idx_o  = w_head_done ? r_tag[w_head] : '0;
   assign bus.res_data_o     = w_head_done ? r_res[w_head] : '0;
   assign bus.err_o          = r_err;

`ifdef SPMM_SCHED_PERF_EN
   logic [31:0] r_perf_rows, r_perf_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_rows  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_acc) r_perf_rows <= r_perf_rows + 32'd1;
         if (bus.row_valid_i && !bus.row_ready_o) r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign bus.perf_rows_o  = r_perf_rows;
   assign bus.perf_stall_o = r_perf_stall;
`else
   assign bus.perf_rows_o  = '0;
   assign bus.perf_stall_o = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_spmm_pe_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// tb_spmm_pe_scheduler: random rows against stub PEs, in-order scoreboard and slot-level reference model.
module tb_spmm_pe_scheduler;
   localparam int DW  = 8;
   localparam int DPS = 5;
   localparam int NPE = 4;
   localparam int RW  = 8;
   localparam int CIW = $clog2(DPS);
   localparam int NIW = CIW + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   spmm_pe_scheduler_if #(.DATA_WIDTH(DW), .DOT_PRODUCT_SIZE(DPS), .NUM_PE(NPE), .ROW_IDX_WIDTH(RW)) bus ();
   spmm_pe_scheduler #(.DATA_WIDTH(DW), .DOT_PRODUCT_SIZE(DPS), .NUM_PE(NPE), .ROW_IDX_WIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stub PE arithmetic: sum of (value + column) over the row's nonzeros plus the descriptor LSB.
   function automatic logic [DW-1:0] ref_result(input logic [DPS*CIW-1:0] col,
                                                input logic [DPS*DW-1:0] val,
                                                input logic [NIW-1:0] ni);
      int s;
      int cnt;
      s   = int'(ni[0]);
      cnt = int'(ni[NIW-1:1]);
      for (int i = 0; i < DPS; i++)
         if (i < cnt) s += int'(val[i*DW +: DW]) + int'(col[i*CIW +: CIW]);
      return DW'(s);
   endfunction

   // ---------------- stub PEs ----------------
   int              max_dly = 6;
   int              s_cnt    [NPE];
   logic [DW-1:0]   stub_res [NPE];
   logic [NPE-1:0]  stub_rdy = '0;
   logic [NPE-1:0]  spur_rdy = '0;

   assign bus.pe_ready_i = stub_rdy | spur_rdy;
   for (genvar g = 0; g < NPE; g++) begin : g_pe_res
      assign bus.pe_result_i[g*DW +: DW] = stub_res[g];
   end

   initial for (int k = 0; k < NPE; k++) begin s_cnt[k] = 0; stub_res[k] = '0; end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NPE; k++) s_cnt[k] = 0;
         stub_rdy = '0;
      end else begin
         #1;
         stub_rdy = '0;
         for (int k = 0; k < NPE; k++) begin
            if (s_cnt[k] != 0) begin
               s_cnt[k]--;
               if (s_cnt[k] == 0) stub_rdy[k] = 1'b1;
            end
            if (bus.pe_valid_o[k]) begin
               stub_res[k] = ref_result(bus.pe_col_idx_o, bus.pe_value_o, bus.pe_node_info_o);
               s_cnt[k]    = $urandom_range(max_dly, 1);
            end
         end
      end
   end

   // ---------------- reference model + scoreboard monitor ----------------
   typedef struct {
      logic [RW-1:0] tag;
      logic [DW-1:0] res;
      int            slot;
   } ent_t;

   ent_t                 exp_q[$];
   int                   mst [NPE];       // 0 idle, 1 busy, 2 done
   logic [NPE-1:0]       exp_pev = '0;
   logic                 exp_err = 1'b0;
   logic [31:0]          m_rows  = '0;
   logic [31:0]          m_stall = '0;
   logic [DPS*CIW-1:0]   a_col;
   logic [DPS*DW-1:0]    a_val;
   logic [NIW-1:0]       a_ni;
   logic                 m_any_idle, m_valid;
   int                   m_tgt;

   initial for (int k = 0; k < NPE; k++) mst[k] = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         for (int k = 0; k < NPE; k++) mst[k] = 0;
         exp_pev = '0;
         exp_err = 1'b0;
         m_rows  = '0;
         m_stall = '0;
      end else begin
         m_any_idle = 1'b0;
         m_tgt      = 0;
         for (int k = NPE - 1; k >= 0; k--)
            if (mst[k] == 0) begin m_any_idle = 1'b1; m_tgt = k; end
         chk("row_ready", bus.row_ready_o, m_any_idle);
         chk("pe_valid", bus.pe_valid_o, exp_pev);
         if (exp_pev != '0) begin
            chk("pe_col_idx", bus.pe_col_idx_o, a_col);
            chk("pe_value", bus.pe_value_o, a_val);
            chk("pe_node_info", bus.pe_node_info_o, a_ni);
         end
         m_valid = (exp_q.size() != 0) && (mst[exp_q[0].slot] == 2);
         chk("res_valid", bus.res_valid_o, m_valid);
         if (m_valid) begin
            chk("res_row_idx", bus.res_row_idx_o, exp_q[0].tag);
            chk("res_data", bus.res_data_o, exp_q[0].res);
         end
         chk("err", bus.err_o, exp_err);
`ifdef SPMM_SCHED_PERF_EN
         chk("perf_rows", bus.perf_rows_o, m_rows);
         chk("perf_stall", bus.perf_stall_o, m_stall);
`else
         chk("perf_rows", bus.perf_rows_o, 0);
         chk("perf_stall", bus.perf_stall_o, 0);
`endif
         // Effects of the coming edge, all from the pre-edge model state.
         for (int k = 0; k < NPE; k++)
            if (bus.pe_ready_i[k]) begin
               if (mst[k] == 1) mst[k] = 2;
               else exp_err = 1'b1;
            end
         exp_pev = '0;
         if (bus.row_valid_i && m_any_idle) begin
            mst[m_tgt] = 1;
            exp_q.push_back('{tag: bus.row_idx_i,
                              res: ref_result(bus.col_idx_i, bus.value_i, bus.node_info_i),
                              slot: m_tgt});
            exp_pev[m_tgt] = 1'b1;
            a_col  = bus.col_idx_i;
            a_val  = bus.value_i;
            a_ni   = bus.node_info_i;
            m_rows = m_rows + 32'd1;
         end
         if (bus.row_valid_i && !m_any_idle) m_stall = m_stall + 32'd1;
         if (m_valid && bus.res_ready_i) begin
            mst[exp_q[0].slot] = 0;
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [RW-1:0] tag_ctr = 8'h01;

   task automatic new_row();
      bus.row_valid_i = 1'b1;
      bus.row_idx_i   = tag_ctr;
      tag_ctr         = tag_ctr + 8'd1;
      for (int i = 0; i < DPS; i++) begin
         bus.col_idx_i[i*CIW +: CIW] = CIW'($urandom_range(DPS - 1));
         bus.value_i[i*DW +: DW]     = DW'($urandom_range(255));
      end
      bus.node_info_i = {(NIW-1)'($urandom_range(DPS)), 1'($urandom_range(1))};
   endtask

   task automatic run_rows(input int n, input int pv, input int pr);
      int   sent = 0;
      int   g    = 0;
      logic acc  = 1'b0;
      while (sent < n && g < 2000) begin
         @(posedge clk); #1;
         g++;
         if (acc) bus.row_valid_i = 1'b0;
         if (!bus.row_valid_i && ($urandom_range(99) < pv)) new_row();
         bus.res_ready_i = ($urandom_range(99) < pr);
         @(negedge clk);
         acc = bus.row_valid_i && bus.row_ready_o;
         if (acc) sent++;
      end
      chk("run_rows_sent", sent, n);
      @(posedge clk); #1;
      bus.row_valid_i = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      @(posedge clk); #1;
      bus.row_valid_i = 1'b0;
      bus.res_ready_i = 1'b1;
      while (exp_q.size() != 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_vals();
      chk("rst_row_ready", bus.row_ready_o, 0);
      chk("rst_pe_valid", bus.pe_valid_o, 0);
      chk("rst_pe_value", bus.pe_value_o, 0);
      chk("rst_pe_col_idx", bus.pe_col_idx_o, 0);
      chk("rst_pe_node_info", bus.pe_node_info_o, 0);
      chk("rst_res_valid", bus.res_valid_o, 0);
      chk("rst_res_row_idx", bus.res_row_idx_o, 0);
      chk("rst_res_data", bus.res_data_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_perf_rows", bus.perf_rows_o, 0);
      chk("rst_perf_stall", bus.perf_stall_o, 0);
   endtask

   logic [DW-1:0] held_data;
   logic [RW-1:0] held_tag;
   logic          held_ok;

   initial begin
      bus.row_valid_i = 1'b0;
      bus.row_idx_i   = '0;
      bus.col_idx_i   = '0;
      bus.value_i     = '0;
      bus.node_info_i = '0;
      bus.res_ready_i = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_vals();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      run_rows(40, 70, 70);
      drain();
      run_rows(40, 100, 100);
      drain();

      // Fill every slot with the consumer stalled, then hold one more row against backpressure.
      run_rows(NPE, 100, 0);
      @(posedge clk); #1;
      new_row();
      bus.res_ready_i = 1'b0;
      held_ok = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("blocked_row_ready", bus.row_ready_o, 0);
         if (held_ok) begin
            chk("held_res_valid", bus.res_valid_o, 1);
            chk("held_res_row_idx", bus.res_row_idx_o, held_tag);
            chk("held_res_data", bus.res_data_o, held_data);
         end else if (bus.res_valid_o) begin
            held_ok   = 1'b1;
            held_tag  = bus.res_row_idx_o;
            held_data = bus.res_data_o;
         end
      end
      @(posedge clk); #1;
      bus.res_ready_i = 1'b1;
      begin
         int g = 0;
         while (!(bus.row_valid_i && bus.row_ready_o) && g < 200) begin
            @(negedge clk);
            g++;
         end
         chk("blocked_row_accepted", bus.row_ready_o, 1);
      end
      drain();

      // Spurious completion on an idle PE.
      @(posedge clk); #1 spur_rdy = 4'b1000;
      @(posedge clk); #1 spur_rdy = '0;
      @(negedge clk);
      chk("spur_err", bus.err_o, 1);
      chk("spur_no_output", bus.res_valid_o, 0);
      repeat (5) @(negedge clk);
      chk("spur_err_sticky", bus.err_o, 1);

      // Asynchronous reset with rows in flight.
      max_dly = 30;
      run_rows(3, 100, 100);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check_reset_vals();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      max_dly = 6;
      run_rows(20, 80, 80);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/spmm_pe_scheduler.md
# spmm_pe_scheduler

Dispatch and collection controller for a pool of sparse dot-product PEs in the SPMM stage. It accepts CSR feature rows over a valid/ready stream and issues each row to the lowest-index idle PE. It captures each PE's result on that PE's one-cycle ready pulse and returns results in row-arrival order, with backpressure. The block sits between the feature-row fetch logic and the NUM_PE PE instances.

## Interface
- DATA_WIDTH, 8, width of a value, weight and result
- DOT_PRODUCT_SIZE, 5, maximum nonzeros per row; sets COL_IDX_WIDTH = $clog2(DOT_PRODUCT_SIZE) and NODE_INFO_WIDTH = COL_IDX_WIDTH+1
- NUM_PE, 4, number of PEs managed (≥2)
- ROW_IDX_WIDTH, 8, width of the row tag carried to the output

Clock and reset are fixed: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- row_valid_i  in  1  input row valid
- row_ready_o  out  1  input row accepted when high with row_valid_i
- row_idx_i  in  ROW_IDX_WIDTH  row tag
- col_idx_i  in  DOT_PRODUCT_SIZE*COL_IDX_WIDTH  flattened column indices
- value_i  in  DOT_PRODUCT_SIZE*DATA_WIDTH  flattened nonzero values
- node_info_i  in  NODE_INFO_WIDTH  row descriptor; bits [NODE_INFO_WIDTH-1:1] = nonzero count
- pe_valid_o  out  NUM_PE  one-hot, one-cycle issue strobe per PE
- pe_col_idx_o, pe_value_o, pe_node_info_o  out  same widths as inputs  registered row broadcast to all PEs
- pe_ready_i  in  NUM_PE  per-PE one-cycle done pulse
- pe_result_i  in  NUM_PE*DATA_WIDTH  flattened PE results; PE k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- res_valid_o  out  1  output result valid
- res_ready_i  in  1  output consumer ready
- res_row_idx_o  out  ROW_IDX_WIDTH  tag of the output result
- res_data_o  out  DATA_WIDTH  output result
- err_o  out  1  sticky protocol error
- perf_rows_o, perf_stall_o  out  32 each  performance counters (see Configuration)

## Operation
- Each PE has a slot in one of three states: IDLE, BUSY or DONE. Each slot holds a tag register and a result register.
- Accept: a row is accepted when row_valid_i && row_ready_o, with row_ready_o = any slot IDLE (registered state only).
- Target slot k is the lowest-index IDLE slot. On acceptance:
  - slot k goes to BUSY and stores row_idx_i;
  - k is pushed into an order FIFO of depth NUM_PE (it cannot overflow);
  - the row fields are registered onto pe_* outputs;
  - pe_valid_o[k] = 1 for exactly the next cycle.
- Completion: pe_ready_i[k] high while slot k is BUSY moves slot k to DONE and latches pe_result_i[k].
- Protocol error: pe_ready_i[k] high while slot k is not BUSY is ignored for data and sets err_o.
- Output: res_valid_o = (order FIFO non-empty) && (head slot is DONE). res_row_idx_o and res_data_o come from the head slot.
- On res_valid_o && res_ready_i, the FIFO pops and the head slot returns to IDLE.
- Results never reorder. A DONE slot behind a non-DONE head waits.
- A zero-count row (node_info count = 0) is dispatched normally; the PE is responsible for producing 0.
- Results pass through unmodified; the PE saturates.

## Timing
- Reset values: row_ready_o 0 during reset and 1 from the first cycle after deassertion; pe_valid_o 0; pe_* data 0; res_valid_o 0; res_* 0; err_o 0; counters 0; all slots IDLE; FIFO empty.
- Dispatch latency: a row accepted at edge T drives pe_valid_o from T to T+1.
- Return latency: pe_ready_i sampled at edge T gives res_valid_o high from T when the slot is at the FIFO head.
- Throughput: one row accepted per cycle while a slot is IDLE.
- A slot freed by a pop at edge T is eligible for acceptance from T onward, not in the same cycle.
- Simultaneous completion of multiple PEs in one cycle: all are latched.
- Simultaneous events on one slot in one cycle (pop plus a pe_ready on a different slot, plus an accept): all take effect independently.
- res_valid_o stays high and res_* stay stable until res_ready_i.
- Asynchronous reset mid-operation drops all in-flight rows and returns every output to its reset value immediately.

## Configuration
- SPMM_SCHED_PERF_EN defined:
  - perf_rows_o counts accepted rows.
  - perf_stall_o counts cycles with row_valid_i && !row_ready_o.
  - Both are 32-bit and wrap at 2^32.
- Not defined: perf_rows_o and perf_stall_o are tied to 0 and no counter flops exist.

## Test plan
- Single row, tag 0x11, stub PE 0 pulses ready with result 0x2A four cycles after pe_valid_o[0] → pe_valid_o = 0001 for one cycle; then res_valid_o with tag 0x11, data 0x2A; slot 0 IDLE after the pop.
- Five back-to-back rows, tags 1..5, NUM_PE=4, PEs hold ready off → pe_valid_o sequence 0001, 0010, 0100, 1000; row_ready_o drops before tag 5.
- Out-of-order completion: PE2, then PE0, then PE1 finish with results 0x30, 0x10, 0x20 for tags A, B, C issued to PE0..PE2 → output order A/0x10, B/0x20, C/0x30.
- res_ready_i held low for 10 cycles with the head DONE → res_valid_o and data stable; no new row is accepted once all slots are IDLE-blocked.
- Spurious pe_ready_i[3] with slot 3 IDLE → err_o = 1 and stays 1; no output is produced.
- Reset asserted while 3 rows are in flight → all outputs reach reset values asynchronously; with SPMM_SCHED_PERF_EN, perf_rows_o = 0.
